z_sq_csa: RTL and testbench



---
 rtl/z_sq_csa_pkg.sv | 20 ++
 rtl/z_csa_block.sv | 22 ++
 rtl/z_sq_csa.sv | 85 ++++++++
 tb/tb_z_sq_csa.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/z_sq_csa_pkg.sv
// Shared sizing helpers for the square-root carry-select adder.
// Stage j is j+2 bits wide, so K stages cover (K+1)(K+2)/2-1 bits.
package z_sq_csa_pkg;

  localparam int K_DEFAULT = 15;

  function automatic int n_of(input int k);
    return (k + 1) * (k + 2) / 2 - 1;
  endfunction

  function automatic int stage_width(input int j);
    return j + 2;
  endfunction

  // Closed form of sum_{i<j}(i+2).
  function automatic int stage_offset(input int j);
    return j * (j + 3) / 2;
  endfunction

endpackage

// File: rtl/z_csa_block.sv
// One carry-select stage: both carry-in outcomes are precomputed,
// and the incoming carry only drives the final select mux.
module z_csa_block #(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_sel,
  output logic [W-1:0] sum,
  output logic         co
);

  logic [W:0] r0;
  logic [W:0] r1;

  assign r0 = {1'b0, a} + {1'b0, b};
  assign r1 = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, 1'b1};

  assign sum = c_sel ? r1[W-1:0] : r0[W-1:0];
  assign co  = c_sel ? r1[W]     : r0[W];

endmodule

// File: rtl/z_sq_csa.sv
// Registered square-root carry-select adder: {c_out, sum} = a + b + c_in.
// Define Z_SQ_CSA_INPUT_REG_EN to register the operands too (latency 2).
module z_sq_csa
  import z_sq_csa_pkg::*;
#(
  parameter  int K = K_DEFAULT,
  localparam int N = n_of(K)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic         out_valid,
  output logic [N-1:0] sum,
  output logic         c_out
);

  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic         c_q;
  logic         v_q;

`ifdef Z_SQ_CSA_INPUT_REG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      a_q <= a;
      b_q <= b;
      c_q <= c_in;
      v_q <= in_valid;
    end
  end
`else
  assign a_q = a;
  assign b_q = b;
  assign c_q = c_in;
  assign v_q = in_valid;
`endif

  logic [N-1:0] sum_comb;
  logic         c_out_comb;

  // Per-stage carry nets keep the chain free of intra-vector loops.
  for (genvar j = 0; j < K; j++) begin : g_stage
    localparam int W = stage_width(j);
    localparam int O = stage_offset(j);
    logic ci;
    logic co;

    if (j == 0) begin : g_c0
      assign ci = c_q;
    end else begin : g_cn
      assign ci = g_stage[j-1].co;
    end

    z_csa_block #(.W(W)) u_blk (
      .a     (a_q[O +: W]),
      .b     (b_q[O +: W]),
      .c_sel (ci),
      .sum   (sum_comb[O +: W]),
      .co    (co)
    );
  end

  assign c_out_comb = g_stage[K-1].co;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= '0;
      c_out     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      sum       <= sum_comb;
      c_out     <= c_out_comb;
      out_valid <= v_q;
    end
  end

endmodule

// File: tb/tb_z_sq_csa.sv
// Scoreboard bench for z_sq_csa: expected sums pushed at issue, popped on out_valid.
module tb_z_sq_csa;

  localparam int K = 15;
  localparam int N = 135;
`ifdef Z_SQ_CSA_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [N-1:0] s;
    logic         c;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic [N-1:0] sum;
  logic         c_out;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  z_sq_csa #(.K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .sum       (sum),
    .c_out     (c_out)
  );

  always #5 clk = ~clk;

  // A reset edge discards everything still in flight.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) q.delete();
  end

  task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_valid: got out_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sum", {1'b0, sum}, {1'b0, e.s});
        check("c_out", {{N{1'b0}}, c_out}, {{N{1'b0}}, e.c});
        check("latency", (N+1)'(cyc), (N+1)'(e.cyc + LAT));
      end
    end
  end

  task automatic drive(input logic v, input logic [N-1:0] ai, input logic [N-1:0] bi,
                       input logic ci, input logic r);
    logic [N:0] t;
    exp_t       e;
    @(posedge clk);
    #1;
    in_valid = v;
    a        = ai;
    b        = bi;
    c_in     = ci;
    rst_n    = r;
    if (v && r) begin
      t = {1'b0, ai} + {1'b0, bi} + (N+1)'(ci);
      e.s = t[N-1:0];
      e.c = t[N];
      e.cyc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sum"}, {1'b0, sum}, '0);
    check({tag, "_c_out"}, {{N{1'b0}}, c_out}, '0);
    check({tag, "_out_valid"}, {{N{1'b0}}, out_valid}, '0);
  endtask

  function automatic logic [N-1:0] rnd();
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) r = (r << 32) | N'($urandom);
    return r;
  endfunction

  initial begin
    logic [N-1:0] ones;
    logic [N-1:0] x;
    logic [N-1:0] y;
    int           off;
    logic         v;
    logic         r;

    ones = '1;

    drive(1'b1, ones, ones, 1'b1, 1'b0);
    drive(1'b1, ones, ones, 1'b1, 1'b0);
    check_reset_outputs("reset");

    drive(1'b1, ones, ones, 1'b1, 1'b1);
    drive(1'b1, ones, '0, 1'b1, 1'b1);

    off = 0;
    for (int j = 0; j < K; j++) begin
      if (j > 0) begin
        x = N'(1) << (off - 1);
        drive(1'b1, x, x, 1'b0, 1'b1);
      end
      off += j + 2;
    end

    for (int i = 0; i < 10000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = !(i == 5000 || i == 5001);
      x = rnd();
      case ($urandom_range(0, 3))
        0:       y = ~x;
        1:       y = ones - x;
        default: y = rnd();
      endcase
      drive(v, x, y, 1'($urandom), r);
      if (i == 5001) check_reset_outputs("midreset");
    end

    repeat (LAT + 3) drive(1'b0, rnd(), rnd(), 1'b0, 1'b1);
    check("drained", (N+1)'(q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
